// File: rtl/multicycle_control_unit.sv
// Multi-cycle FSM control unit for the 16-bit Von Neumann RISC: sequences
// fetch/decode/execute/memory/writeback over one shared memory port.
module multicycle_control_unit #(
  parameter int OPCODE_W       = 4,
  parameter int ALU_OP_W       = 4,
  parameter int TIMEOUT_W      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode_in,
  input  logic                alu_zero_flag_in,
  input  logic                mem_ready_in,
  input  logic                run_in,
  output logic                pc_write_enable_out,
  output logic                ir_write_enable_out,
  output logic                reg_write_enable_out,
  output logic                mem_read_enable_out,
  output logic                mem_write_enable_out,
  output logic [ALU_OP_W-1:0] alu_opcode_out,
  output logic                alu_src_select_out,
  output logic                mem_to_reg_select_out,
  output logic                jump_enable_out,
  output logic                branch_enable_out,
  output logic                mem_address_select_out,
  output logic                halt_cpu_out,
  output logic                illegal_opcode_out,
  output logic                bus_timeout_out,
  output logic [2:0]          state_out
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5,
    S_RESET     = 3'd6
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(4'b0000);
  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(4'b0001);
  localparam logic [OPCODE_W-1:0] OP_NOT  = OPCODE_W'(4'b0110);
  localparam logic [OPCODE_W-1:0] OP_MOV  = OPCODE_W'(4'b0111);
  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(4'b1000);
  localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(4'b1001);
  localparam logic [OPCODE_W-1:0] OP_BEQZ = OPCODE_W'(4'b1010);
  localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(4'b1011);
  localparam logic [OPCODE_W-1:0] OP_HLT  = OPCODE_W'(4'b1110);

  localparam logic [ALU_OP_W-1:0]  ALU_BYPASS   = '1;
  localparam logic [ALU_OP_W-1:0]  ALU_ADD      = ALU_OP_W'(4'b0001);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [OPCODE_W-1:0]    opcode_q, opcode_d;
  logic [TIMEOUT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                   illegal_q, illegal_d;
  logic                   timeout_q, timeout_d;
  logic                   timeout_hit;

  function automatic logic is_alu_op(input logic [OPCODE_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_NOT);
  endfunction

  function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
    return (op <= OP_JMP) || (op == OP_HLT);
  endfunction

  // The timeout fires on the wait cycle that would bring the count up to the limit.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !mem_ready_in && (wait_cnt_q == TIMEOUT_LAST);

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    wait_cnt_d = wait_cnt_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH, S_MEMORY: begin
        if (mem_ready_in) begin
          if (state_q == S_FETCH)     state_d = S_DECODE;
          else if (opcode_q == OP_LD) state_d = S_WRITEBACK;
          else                        state_d = S_FETCH;
        end else if (timeout_hit) begin
          state_d   = S_HALT;
          timeout_d = 1'b1;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        opcode_d = opcode_in;
        if (opcode_in == OP_NOP)      state_d = S_FETCH;
        else if (opcode_in == OP_HLT) state_d = S_HALT;
        else if (!is_legal(opcode_in)) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else                      state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (is_alu_op(opcode_q) || opcode_q == OP_MOV)  state_d = S_WRITEBACK;
        else if (opcode_q == OP_LD || opcode_q == OP_ST) state_d = S_MEMORY;
        else                                             state_d = S_FETCH;
      end
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT: begin
        if (run_in) begin
          state_d   = S_FETCH;
          illegal_d = 1'b0;
          timeout_d = 1'b0;
        end
      end
      default: state_d = S_RESET;
    endcase
    // Every fresh memory access starts its wait count from zero.
    if ((state_d == S_FETCH || state_d == S_MEMORY) && (state_d != state_q))
      wait_cnt_d = '0;
  end

  always_comb begin
    pc_write_enable_out    = 1'b0;
    ir_write_enable_out    = 1'b0;
    reg_write_enable_out   = 1'b0;
    mem_read_enable_out    = 1'b0;
    mem_write_enable_out   = 1'b0;
    alu_opcode_out         = ALU_BYPASS;
    alu_src_select_out     = 1'b0;
    mem_to_reg_select_out  = 1'b0;
    jump_enable_out        = 1'b0;
    branch_enable_out      = 1'b0;
    mem_address_select_out = 1'b0;
    halt_cpu_out           = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_enable_out = 1'b1;
        ir_write_enable_out = mem_ready_in;
        pc_write_enable_out = mem_ready_in;
      end
      S_EXECUTE: begin
        if (is_alu_op(opcode_q)) begin
          alu_opcode_out = ALU_OP_W'(opcode_q);
        end else if (opcode_q == OP_MOV) begin
          alu_opcode_out     = ALU_ADD;
          alu_src_select_out = 1'b1;
        end else if (opcode_q == OP_LD || opcode_q == OP_ST) begin
          mem_address_select_out = 1'b1;
        end else if (opcode_q == OP_BEQZ) begin
          alu_src_select_out  = 1'b1;
          branch_enable_out   = alu_zero_flag_in;
          pc_write_enable_out = alu_zero_flag_in;
        end else if (opcode_q == OP_JMP) begin
          jump_enable_out     = 1'b1;
          pc_write_enable_out = 1'b1;
        end
      end
      S_MEMORY: begin
        mem_address_select_out = 1'b1;
        mem_read_enable_out    = (opcode_q == OP_LD);
        mem_write_enable_out   = (opcode_q == OP_ST);
      end
      S_WRITEBACK: begin
        reg_write_enable_out = 1'b1;
        if (is_alu_op(opcode_q)) begin
          alu_opcode_out = ALU_OP_W'(opcode_q);
        end else if (opcode_q == OP_MOV) begin
          alu_opcode_out     = ALU_ADD;
          alu_src_select_out = 1'b1;
        end else if (opcode_q == OP_LD) begin
          mem_to_reg_select_out = 1'b1;
        end
      end
      S_HALT: halt_cpu_out = 1'b1;
      default: ;
    endcase
  end

  assign illegal_opcode_out = illegal_q;
  assign bus_timeout_out    = timeout_q;
  assign state_out          = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RESET;
      opcode_q   <= '0;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: a per-instruction vector table
// plus hand sequences for memory waits, faults, timeout and async reset.
module tb_multicycle_control_unit;

  logic       clk;
  logic       rst_n;
  logic [3:0] opcode_in;
  logic       alu_zero_flag_in;
  logic       mem_ready_in;
  logic       run_in;
  logic       pc_write_enable_out;
  logic       ir_write_enable_out;
  logic       reg_write_enable_out;
  logic       mem_read_enable_out;
  logic       mem_write_enable_out;
  logic [3:0] alu_opcode_out;
  logic       alu_src_select_out;
  logic       mem_to_reg_select_out;
  logic       jump_enable_out;
  logic       branch_enable_out;
  logic       mem_address_select_out;
  logic       halt_cpu_out;
  logic       illegal_opcode_out;
  logic       bus_timeout_out;
  logic [2:0] state_out;

  int total_checks;
  int passed_checks;

  multicycle_control_unit #(
    .OPCODE_W(4), .ALU_OP_W(4), .TIMEOUT_W(8), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .opcode_in(opcode_in),
    .alu_zero_flag_in(alu_zero_flag_in),
    .mem_ready_in(mem_ready_in),
    .run_in(run_in),
    .pc_write_enable_out(pc_write_enable_out),
    .ir_write_enable_out(ir_write_enable_out),
    .reg_write_enable_out(reg_write_enable_out),
    .mem_read_enable_out(mem_read_enable_out),
    .mem_write_enable_out(mem_write_enable_out),
    .alu_opcode_out(alu_opcode_out),
    .alu_src_select_out(alu_src_select_out),
    .mem_to_reg_select_out(mem_to_reg_select_out),
    .jump_enable_out(jump_enable_out),
    .branch_enable_out(branch_enable_out),
    .mem_address_select_out(mem_address_select_out),
    .halt_cpu_out(halt_cpu_out),
    .illegal_opcode_out(illegal_opcode_out),
    .bus_timeout_out(bus_timeout_out),
    .state_out(state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic       zero;
    int         cycles;
    int         reg_we;
    int         pc_we;
    int         rd;
    int         wr;
    int         br;
    int         jmp;
    int         m2r;
    logic [3:0] alu_wb;
    logic       src_wb;
  } vec_t;

  vec_t vecs[13];

  task automatic check_output(input string name, input int actual, input int expected);
    total_checks++;
    if (actual == expected) passed_checks++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Sample point sits 2 time units after the rising edge, well away from it.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  // Runs one instruction from a FETCH cycle until the unit is back in FETCH (or HALT).
  task automatic run_vector(input vec_t v, input int idx);
    int cycles = 0, reg_we = 0, pc_we = 0, rd = 0, wr = 0, br = 0, jmp = 0, m2r = 0;
    logic [3:0] alu_wb = 4'hf;
    logic       src_wb = 1'b0;
    string tag;
    tag = $sformatf("vec%0d_op%0h", idx, v.op);
    opcode_in        = v.op;
    alu_zero_flag_in = v.zero;
    mem_ready_in     = 1'b1;
    #1;
    check_output({tag, "_start_state"}, state_out, 0);
    do begin
      cycles++;
      reg_we += reg_write_enable_out;
      pc_we  += pc_write_enable_out;
      rd     += mem_read_enable_out;
      wr     += mem_write_enable_out;
      br     += branch_enable_out;
      jmp    += jump_enable_out;
      m2r    += mem_to_reg_select_out;
      if (reg_write_enable_out) begin
        alu_wb = alu_opcode_out;
        src_wb = alu_src_select_out;
      end
      next_cycle();
    end while (state_out != 3'd0 && state_out != 3'd5 && cycles < 20);
    check_output({tag, "_cycles"}, cycles, v.cycles);
    check_output({tag, "_reg_we"}, reg_we, v.reg_we);
    check_output({tag, "_pc_we"}, pc_we, v.pc_we);
    check_output({tag, "_mem_rd"}, rd, v.rd);
    check_output({tag, "_mem_wr"}, wr, v.wr);
    check_output({tag, "_branch"}, br, v.br);
    check_output({tag, "_jump"}, jmp, v.jmp);
    check_output({tag, "_mem2reg"}, m2r, v.m2r);
    check_output({tag, "_alu_wb"}, alu_wb, v.alu_wb);
    check_output({tag, "_src_wb"}, src_wb, v.src_wb);
  endtask

  initial begin
    logic [2:0] add_states[5];
    int         hits;
    total_checks  = 0;
    passed_checks = 0;

    //            op    z     cyc reg pc rd wr br jmp m2r alu    src
    vecs[0]  = '{4'h0, 1'b0, 2, 0, 1, 1, 0, 0, 0, 0, 4'hf, 1'b0};
    vecs[1]  = '{4'h1, 1'b0, 4, 1, 1, 1, 0, 0, 0, 0, 4'h1, 1'b0};
    vecs[2]  = '{4'h2, 1'b0, 4, 1, 1, 1, 0, 0, 0, 0, 4'h2, 1'b0};
    vecs[3]  = '{4'h3, 1'b0, 4, 1, 1, 1, 0, 0, 0, 0, 4'h3, 1'b0};
    vecs[4]  = '{4'h4, 1'b0, 4, 1, 1, 1, 0, 0, 0, 0, 4'h4, 1'b0};
    vecs[5]  = '{4'h5, 1'b0, 4, 1, 1, 1, 0, 0, 0, 0, 4'h5, 1'b0};
    vecs[6]  = '{4'h6, 1'b0, 4, 1, 1, 1, 0, 0, 0, 0, 4'h6, 1'b0};
    vecs[7]  = '{4'h7, 1'b0, 4, 1, 1, 1, 0, 0, 0, 0, 4'h1, 1'b1};
    vecs[8]  = '{4'h8, 1'b0, 5, 1, 1, 2, 0, 0, 0, 1, 4'hf, 1'b0};
    vecs[9]  = '{4'h9, 1'b0, 4, 0, 1, 1, 1, 0, 0, 0, 4'hf, 1'b0};
    vecs[10] = '{4'ha, 1'b1, 3, 0, 2, 1, 0, 1, 0, 0, 4'hf, 1'b0};
    vecs[11] = '{4'ha, 1'b0, 3, 0, 1, 1, 0, 0, 0, 0, 4'hf, 1'b0};
    vecs[12] = '{4'hb, 1'b0, 3, 0, 2, 1, 0, 0, 1, 0, 4'hf, 1'b0};

    rst_n            = 1'b0;
    opcode_in        = 4'h1;
    alu_zero_flag_in = 1'b0;
    mem_ready_in     = 1'b1;
    run_in           = 1'b0;
    repeat (2) next_cycle();
    check_output("reset_state", state_out, 6);
    check_output("reset_alu_op", alu_opcode_out, 4'hf);
    check_output("reset_mem_rd", mem_read_enable_out, 0);
    check_output("reset_pc_we", pc_write_enable_out, 0);
    check_output("reset_flags", {halt_cpu_out, illegal_opcode_out, bus_timeout_out}, 0);

    // ADD with ready high: one RESET cycle, then 0-1-2-4-0.
    rst_n = 1'b1;
    #1;
    check_output("release_still_reset", state_out, 6);
    add_states = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      check_output($sformatf("add_seq_state%0d", i), state_out, add_states[i]);
      if (reg_write_enable_out) begin
        hits++;
        check_output("add_wb_alu_op", alu_opcode_out, 4'h1);
      end
    end
    check_output("add_reg_we_pulses", hits, 1);

    foreach (vecs[i]) run_vector(vecs[i], i);

    // LD with three wait cycles in MEMORY.
    opcode_in    = 4'h8;
    mem_ready_in = 1'b1;
    next_cycle();
    next_cycle();
    check_output("ld_exec_state", state_out, 2);
    check_output("ld_exec_addr_sel", mem_address_select_out, 1);
    next_cycle();
    hits = 0;
    for (int k = 0; k < 4; k++) begin
      mem_ready_in = (k == 3);
      #1;
      if (state_out == 3'd3 && mem_read_enable_out && mem_address_select_out) hits++;
      next_cycle();
    end
    check_output("ld_wait_rd_cycles", hits, 4);
    check_output("ld_wb_state", state_out, 4);
    check_output("ld_wb_mem2reg", mem_to_reg_select_out, 1);
    check_output("ld_wb_reg_we", reg_write_enable_out, 1);
    next_cycle();
    check_output("ld_back_to_fetch", state_out, 0);

    // Illegal opcode 1111 traps into HALT; run_in clears the flag.
    opcode_in = 4'hf;
    next_cycle();
    next_cycle();
    check_output("illegal_state", state_out, 5);
    check_output("illegal_flag", illegal_opcode_out, 1);
    check_output("illegal_halt", halt_cpu_out, 1);
    check_output("illegal_no_strobes", {pc_write_enable_out, mem_read_enable_out, reg_write_enable_out}, 0);
    run_in = 1'b1;
    next_cycle();
    run_in = 1'b0;
    check_output("resume_state", state_out, 0);
    check_output("resume_flag_cleared", illegal_opcode_out, 0);
    check_output("resume_halt_cleared", halt_cpu_out, 0);

    // HLT reaches HALT in two cycles without a fault.
    opcode_in = 4'he;
    next_cycle();
    next_cycle();
    check_output("hlt_state", state_out, 5);
    check_output("hlt_no_illegal", illegal_opcode_out, 0);
    run_in = 1'b1;
    next_cycle();
    run_in = 1'b0;
    check_output("hlt_resume_state", state_out, 0);

    // Fetch timeout after four wait cycles; run_in outside HALT is ignored.
    opcode_in    = 4'h0;
    mem_ready_in = 1'b0;
    run_in       = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      run_in = 1'b0;
      if (k < 4) check_output($sformatf("timeout_wait%0d_state", k), state_out, 0);
    end
    check_output("timeout_state", state_out, 5);
    check_output("timeout_flag", bus_timeout_out, 1);
    check_output("timeout_halt", halt_cpu_out, 1);
    run_in = 1'b1;
    next_cycle();
    run_in = 1'b0;
    check_output("timeout_cleared", bus_timeout_out, 0);
    check_output("timeout_resume_state", state_out, 0);

    // Ready on the fourth wait cycle wins over the timeout.
    repeat (3) next_cycle();
    mem_ready_in = 1'b1;
    #1;
    check_output("late_ready_ir_we", ir_write_enable_out, 1);
    next_cycle();
    check_output("late_ready_decode", state_out, 1);
    check_output("late_ready_no_timeout", bus_timeout_out, 0);
    next_cycle();
    check_output("late_ready_nop_fetch", state_out, 0);

    // Asynchronous reset while HALTed clears the sticky flag immediately.
    opcode_in = 4'hd;
    next_cycle();
    next_cycle();
    check_output("illegal2_flag", illegal_opcode_out, 1);
    rst_n = 1'b0;
    #1;
    check_output("async_rst_flag_cleared", illegal_opcode_out, 0);
    check_output("async_rst_halt_state", state_out, 6);
    next_cycle();
    rst_n = 1'b1;
    #1;
    check_output("async_rst_release_hold", state_out, 6);
    next_cycle();
    check_output("async_rst_to_fetch", state_out, 0);

    // Reset during a ST memory wait drops the write strobe asynchronously.
    opcode_in    = 4'h9;
    mem_ready_in = 1'b1;
    next_cycle();
    next_cycle();
    next_cycle();
    mem_ready_in = 1'b0;
    #1;
    check_output("st_wait_state", state_out, 3);
    check_output("st_wait_wr", mem_write_enable_out, 1);
    next_cycle();
    check_output("st_wait2_wr", mem_write_enable_out, 1);
    rst_n = 1'b0;
    #1;
    check_output("st_rst_wr_dropped", mem_write_enable_out, 0);
    check_output("st_rst_addr_sel", mem_address_select_out, 0);
    check_output("st_rst_state", state_out, 6);
    next_cycle();
    check_output("st_rst_held", state_out, 6);
    rst_n = 1'b1;
    #1;
    check_output("st_rst_release_hold", state_out, 6);
    next_cycle();
    check_output("st_rst_fetch", state_out, 0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
